// File: rtl/mem_b_reader.sv
`default_nettype none
// ============================================================================
// Module   : mem_b_reader
// Brief    : 4 x 8-bit result store. Entries are loaded from the writer side,
//            then drained through a valid/ready read port on Start.
// Revision : 1.0 - initial release
// ============================================================================
module mem_b_reader (
  input  logic       clock,
  input  logic       Reset,
  input  logic       WEB,
  input  logic [7:0] DataInB,
  input  logic       Start,
  input  logic       RdReady,
  output logic       RdValid,
  output logic [7:0] RdData,
  output logic [1:0] RdAddr,
  output logic       Full,
  output logic       Done
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] mem [4];
  logic [1:0] wptr;
  logic [1:0] rptr;
  logic       full;
  logic       rd_valid;
  logic       done;
  logic       write_en;

  // Gating on Reset keeps writes issued during reset from landing in storage.
  assign write_en = Reset && (state == LOAD) && WEB && !full;

  // Storage is deliberately not reset; its contents outlive a load/drain cycle.
  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[wptr] <= DataInB;
    end
  end

  always_ff @(posedge clock) begin
    if (!Reset) begin
      state    <= LOAD;
      wptr     <= 2'd0;
      rptr     <= 2'd0;
      full     <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          // Start only counts once Full is already registered high, so a
          // Start coinciding with the fourth write is dropped.
          if (full && Start) begin
            state    <= READ;
            rptr     <= 2'd0;
            rd_valid <= 1'b1;
          end else if (WEB && !full) begin
            wptr <= wptr + 2'd1;
            if (wptr == 2'd3) begin
              full <= 1'b1;
            end
          end
        end

        READ: begin
          if (RdReady) begin
            rptr <= rptr + 2'd1;
            if (rptr == 2'd3) begin
              state    <= DONE;
              rd_valid <= 1'b0;
              done     <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= LOAD;
          done  <= 1'b0;
          full  <= 1'b0;
          wptr  <= 2'd0;
          rptr  <= 2'd0;
        end

        default: begin
          state    <= LOAD;
          rd_valid <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  assign RdValid = rd_valid;
  assign RdAddr  = rptr;
  assign Full    = full;
  assign Done    = done;
  assign RdData  = mem[rptr];

endmodule
`default_nettype wire

// File: tb/tb_mem_b_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_b_reader
// Brief    : Scoreboard bench for mem_b_reader with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_b_reader;

  logic       clock   = 1'b0;
  logic       Reset   = 1'b0;
  logic       WEB     = 1'b0;
  logic [7:0] DataInB = 8'h00;
  logic       Start   = 1'b0;
  logic       RdReady = 1'b0;
  logic       RdValid;
  logic [7:0] RdData;
  logic [1:0] RdAddr;
  logic       Full;
  logic       Done;

  mem_b_reader dut (
    .clock   (clock),
    .Reset   (Reset),
    .WEB     (WEB),
    .DataInB (DataInB),
    .Start   (Start),
    .RdReady (RdReady),
    .RdValid (RdValid),
    .RdData  (RdData),
    .RdAddr  (RdAddr),
    .Full    (Full),
    .Done    (Done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit run      = 1'b0;

  // Expected read beats {addr, data}, consumed by the monitor.
  logic [9:0] exp_q [$];

  // Reference model: entries stored, how many loaded, how many drained,
  // and phase 0 = loading, 1 = draining, 2 = completion cycle.
  logic [7:0] m_mem [4];
  bit         m_ok  [4];
  int         m_count = 0;
  int         m_ridx  = 0;
  int         m_phase = 0;

  int pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_outputs();
    check("full",     32'(Full),    32'(m_count == 4));
    check("rd_valid", 32'(RdValid), 32'(m_phase == 1));
    check("done",     32'(Done),    32'(m_phase == 2));
    check("rd_addr",  32'(RdAddr),  32'(m_ridx % 4));
  endtask

  task automatic step(input bit web, input logic [7:0] data, input bit start, input bit ready);
    WEB = web; DataInB = data; Start = start; RdReady = ready;
    @(posedge clock); #1;
    case (m_phase)
      0: begin
        if (start && m_count == 4) begin
          m_phase = 1;
          m_ridx  = 0;
          for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), m_mem[i]});
        end else if (web && m_count < 4) begin
          m_mem[2'(m_count)] = data;
          m_ok[2'(m_count)]  = 1'b1;
          m_count++;
        end
      end
      1: begin
        if (ready) begin
          m_ridx++;
          if (m_ridx == 4) m_phase = 2;
        end
      end
      default: begin
        m_phase = 0;
        m_count = 0;
        m_ridx  = 0;
      end
    endcase
    WEB = 1'b0; Start = 1'b0;
    check_outputs();
  endtask

  // Two-cycle reset with WEB/Start possibly asserted; both must be ignored.
  task automatic do_reset(input bit web, input bit start);
    Reset = 1'b0; WEB = web; Start = start; DataInB = 8'hEE; RdReady = 1'b1;
    m_phase = 0; m_count = 0; m_ridx = 0;
    @(posedge clock); #1;
    exp_q.delete();
    check_outputs();
    if (m_ok[0]) check("reset_rd_data", 32'(RdData), 32'(m_mem[0]));
    @(posedge clock); #1;
    Reset = 1'b1; WEB = 1'b0; Start = 1'b0;
    check_outputs();
  endtask

  // mode 0: always ready, junk WEB=1/0xAA; mode 1: fixed backpressure pattern;
  // mode 2: random ready. abort_at >= 0 resets after that many transfers.
  task automatic drain(input int mode, input int abort_at);
    int k;
    bit rdy;
    k = 0;
    while (m_phase != 0 && k < 200) begin
      if (abort_at >= 0 && m_phase == 1 && m_ridx == abort_at) begin
        do_reset(1'b1, 1'b1);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (k < 7) ? (pat[k] != 0) : 1'b1;
        default: rdy = (k > 40) ? 1'b1 : ($urandom_range(0, 1) == 1);
      endcase
      step((mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1, 8'hAA,
           ($urandom_range(0, 1) == 1), rdy);
      k++;
    end
    if (m_phase != 0) check("drain_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: every presented beat must match the head of the scoreboard;
  // it is retired when RdReady accepts it on the coming edge.
  always @(negedge clock) begin
    if (run && Reset === 1'b1 && RdValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected_beat", 32'd1, 32'd0);
      end else begin
        check("sb_rd_addr", 32'(RdAddr), 32'(exp_q[0][9:8]));
        check("sb_rd_data", 32'(RdData), 32'(exp_q[0][7:0]));
        if (RdReady === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    do_reset(1'b0, 1'b0);
    run = 1'b1;

    // Fill then drain at full rate.
    step(1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 8'h07, 1'b0, 1'b0);
    step(1'b1, 8'hFD, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    drain(0, -1);

    // Overfill: only the first four bytes are kept.
    for (int i = 0; i < 6; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    drain(0, -1);

    // Early Start and Start coinciding with the fourth write are both dropped.
    step(1'b1, 8'h21, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h23, 1'b0, 1'b0);
    step(1'b1, 8'h24, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    drain(1, -1);

    // Reset after the second transfer, then a fresh load.
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    drain(2, 2);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    drain(2, -1);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_reset($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end else begin
        step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 9) == 0, 1'b0);
        if (m_phase == 1)
          drain(2, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
      end
    end

    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
